// File: rtl/idex_alu_decode.sv
// ---------------------------------------------------------------------------
// idex_alu_decode
//
// ID/EX boundary of a MIPS-style pipeline. The ID-stage instruction word is
// decoded combinationally into ALU control, operand selection and write
// enables. The result is captured in the EX pipeline register.
//
// Parameters
//   ILLEGAL_AS_NOP  1: an illegal instruction enters EX as a bubble (ex_valid=0)
//                   0: it enters EX as valid with every write enable cleared
//                   In both cases ex_illegal is raised for that EX occupancy.
//
// Ports
//   clk             sole clock, rising edge
//   rst_n           synchronous active-low reset
//   instr           ID-stage instruction word
//   in_valid        instr/rd1/rd2 carry a real instruction
//   rd1, rd2        register-file read data for rs / rt
//   stall           hold the EX register contents
//   flush           insert a bubble into EX (wins over stall)
//   ex_valid        EX register holds a real instruction
//   ex_alu_control  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 pass SrcB
//   ex_srca         ALU operand A (always rd1)
//   ex_srcb         ALU operand B after the immediate mux
//   ex_wdata        store data (rd2)
//   ex_write_reg    destination register number
//   ex_reg_write, ex_mem_write, ex_mem_to_reg, ex_branch  EX control bits
//   ex_illegal      instruction in EX decoded as illegal
// ---------------------------------------------------------------------------
module idex_alu_decode #(
  parameter bit ILLEGAL_AS_NOP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        in_valid,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  input  logic        stall,
  input  logic        flush,
  output logic        ex_valid,
  output logic [2:0]  ex_alu_control,
  output logic [31:0] ex_srca,
  output logic [31:0] ex_srcb,
  output logic [31:0] ex_wdata,
  output logic [4:0]  ex_write_reg,
  output logic        ex_reg_write,
  output logic        ex_mem_write,
  output logic        ex_mem_to_reg,
  output logic        ex_branch,
  output logic        ex_illegal
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  // R-type function codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU control encodings
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_PASS = 3'b101;

  // Instruction fields
  logic [5:0]  op_s;
  logic [5:0]  funct_s;
  logic [31:0] imm_sext_s;
  logic [31:0] imm_zext_s;
  logic [31:0] imm_lui_s;

  // Combinational decode results
  logic [2:0]  dec_alu_s;
  logic [31:0] dec_srcb_s;
  logic [4:0]  dec_write_reg_s;
  logic        dec_reg_write_s;
  logic        dec_mem_write_s;
  logic        dec_mem_to_reg_s;
  logic        dec_branch_s;
  logic        dec_illegal_s;

  // Values presented to the EX register on a normal load
  logic        ld_valid_s;
  logic        ld_illegal_s;
  logic        ld_reg_write_s;
  logic        ld_mem_write_s;
  logic        ld_mem_to_reg_s;
  logic        ld_branch_s;

  // EX pipeline register
  logic        valid_r;
  logic [2:0]  alu_control_r;
  logic [31:0] srca_r;
  logic [31:0] srcb_r;
  logic [31:0] wdata_r;
  logic [4:0]  write_reg_r;
  logic        reg_write_r;
  logic        mem_write_r;
  logic        mem_to_reg_r;
  logic        branch_r;
  logic        illegal_r;

  assign op_s       = instr[31:26];
  assign funct_s    = instr[5:0];
  assign imm_sext_s = {{16{instr[15]}}, instr[15:0]};
  assign imm_zext_s = {16'h0000, instr[15:0]};
  assign imm_lui_s  = {instr[15:0], 16'h0000};

  // Instruction decode: ALU op, operand B select, destination and enables.
  // Illegal encodings keep every write enable at 0 and ALU control at add.
  always_comb begin
    dec_alu_s        = ALU_ADD;
    dec_srcb_s       = rd2;
    dec_write_reg_s  = instr[20:16];
    dec_reg_write_s  = 1'b0;
    dec_mem_write_s  = 1'b0;
    dec_mem_to_reg_s = 1'b0;
    dec_branch_s     = 1'b0;
    dec_illegal_s    = 1'b0;

    case (op_s)
      OP_RTYPE: begin
        dec_srcb_s      = rd2;
        dec_write_reg_s = instr[15:11];
        case (funct_s)
          FN_ADD: begin
            dec_alu_s       = ALU_ADD;
            dec_reg_write_s = 1'b1;
          end
          FN_SUB: begin
            dec_alu_s       = ALU_SUB;
            dec_reg_write_s = 1'b1;
          end
          FN_AND: begin
            dec_alu_s       = ALU_AND;
            dec_reg_write_s = 1'b1;
          end
          FN_OR: begin
            dec_alu_s       = ALU_OR;
            dec_reg_write_s = 1'b1;
          end
          FN_SLT: begin
            dec_alu_s       = ALU_SLT;
            dec_reg_write_s = 1'b1;
          end
          // Includes funct 000000, so the all-zero word (sll $0) is illegal.
          default: begin
            dec_alu_s     = ALU_ADD;
            dec_illegal_s = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        dec_alu_s        = ALU_ADD;
        dec_srcb_s       = imm_sext_s;
        dec_reg_write_s  = 1'b1;
        dec_mem_to_reg_s = 1'b1;
      end
      OP_SW: begin
        dec_alu_s       = ALU_ADD;
        dec_srcb_s      = imm_sext_s;
        dec_mem_write_s = 1'b1;
      end
      OP_BEQ: begin
        dec_alu_s    = ALU_SUB;
        dec_srcb_s   = rd2;
        dec_branch_s = 1'b1;
      end
      OP_ADDI: begin
        dec_alu_s       = ALU_ADD;
        dec_srcb_s      = imm_sext_s;
        dec_reg_write_s = 1'b1;
      end
      OP_SLTI: begin
        dec_alu_s       = ALU_SLT;
        dec_srcb_s      = imm_sext_s;
        dec_reg_write_s = 1'b1;
      end
      OP_ANDI: begin
        dec_alu_s       = ALU_AND;
        dec_srcb_s      = imm_zext_s;
        dec_reg_write_s = 1'b1;
      end
      OP_ORI: begin
        dec_alu_s       = ALU_OR;
        dec_srcb_s      = imm_zext_s;
        dec_reg_write_s = 1'b1;
      end
      OP_LUI: begin
        dec_alu_s       = ALU_PASS;
        dec_srcb_s      = imm_lui_s;
        dec_reg_write_s = 1'b1;
      end
      default: begin
        dec_alu_s     = ALU_ADD;
        dec_illegal_s = 1'b1;
      end
    endcase
  end

  // Qualify decode with in_valid; a non-valid slot becomes a bubble.
  // The illegal flag survives even when the instruction itself is dropped
  // as a bubble, so downstream exception logic still sees it.
  always_comb begin
    ld_illegal_s    = in_valid & dec_illegal_s;
    ld_reg_write_s  = in_valid & dec_reg_write_s;
    ld_mem_write_s  = in_valid & dec_mem_write_s;
    ld_mem_to_reg_s = in_valid & dec_mem_to_reg_s;
    ld_branch_s     = in_valid & dec_branch_s;
    if (ILLEGAL_AS_NOP) begin
      ld_valid_s = in_valid & ~dec_illegal_s;
    end else begin
      ld_valid_s = in_valid;
    end
  end

  // EX control register: reset > flush (bubble) > stall (hold) > load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r       <= 1'b0;
      alu_control_r <= 3'b000;
      reg_write_r   <= 1'b0;
      mem_write_r   <= 1'b0;
      mem_to_reg_r  <= 1'b0;
      branch_r      <= 1'b0;
      illegal_r     <= 1'b0;
    end else if (flush) begin
      valid_r       <= 1'b0;
      alu_control_r <= 3'b000;
      reg_write_r   <= 1'b0;
      mem_write_r   <= 1'b0;
      mem_to_reg_r  <= 1'b0;
      branch_r      <= 1'b0;
      illegal_r     <= 1'b0;
    end else if (!stall) begin
      valid_r       <= ld_valid_s;
      alu_control_r <= dec_alu_s;
      reg_write_r   <= ld_reg_write_s;
      mem_write_r   <= ld_mem_write_s;
      mem_to_reg_r  <= ld_mem_to_reg_s;
      branch_r      <= ld_branch_s;
      illegal_r     <= ld_illegal_s;
    end
  end

  // EX data register: operands and destination. Contents are don't-care
  // under a bubble, so flush simply leaves them untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      srca_r      <= 32'h0000_0000;
      srcb_r      <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
      write_reg_r <= 5'd0;
    end else if (!flush && !stall) begin
      srca_r      <= rd1;
      srcb_r      <= dec_srcb_s;
      wdata_r     <= rd2;
      write_reg_r <= dec_write_reg_s;
    end
  end

  assign ex_valid       = valid_r;
  assign ex_alu_control = alu_control_r;
  assign ex_srca        = srca_r;
  assign ex_srcb        = srcb_r;
  assign ex_wdata       = wdata_r;
  assign ex_write_reg   = write_reg_r;
  assign ex_reg_write   = reg_write_r;
  assign ex_mem_write   = mem_write_r;
  assign ex_mem_to_reg  = mem_to_reg_r;
  assign ex_branch      = branch_r;
  assign ex_illegal     = illegal_r;

endmodule

// File: tb/tb_idex_alu_decode.sv
// ---------------------------------------------------------------------------
// tb_idex_alu_decode
//
// Directed testbench for idex_alu_decode (ILLEGAL_AS_NOP = 1). Inputs change
// 1 time unit after a rising edge; outputs are sampled 1 time unit after the
// next rising edge. Expected values are hand-computed from the encodings.
// ---------------------------------------------------------------------------
module tb_idex_alu_decode;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        in_valid;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [2:0]  ex_alu_control;
  logic [31:0] ex_srca;
  logic [31:0] ex_srcb;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_write_reg;
  logic        ex_reg_write;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic        ex_branch;
  logic        ex_illegal;

  int checks = 0;
  int passed = 0;

  // {valid, reg_write, mem_write, mem_to_reg, branch, illegal}
  logic [5:0] ctrl;
  assign ctrl = {ex_valid, ex_reg_write, ex_mem_write, ex_mem_to_reg, ex_branch, ex_illegal};

  idex_alu_decode #(.ILLEGAL_AS_NOP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .in_valid(in_valid),
    .rd1(rd1), .rd2(rd2), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_alu_control(ex_alu_control),
    .ex_srca(ex_srca), .ex_srcb(ex_srcb), .ex_wdata(ex_wdata),
    .ex_write_reg(ex_write_reg), .ex_reg_write(ex_reg_write),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_branch(ex_branch), .ex_illegal(ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    instr = i; rd1 = a; rd2 = b; in_valid = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    instr = 32'h00851020; rd1 = 32'd7; rd2 = 32'd9; in_valid = 1'b1;
    tick(); tick();
    checks++; if (ctrl !== 6'b000000) $display("FAIL reset_ctrl: got %b exp %b", ctrl, 6'b000000); else passed++;
    checks++; if (ex_alu_control !== 3'b000) $display("FAIL reset_alu: got %b exp %b", ex_alu_control, 3'b000); else passed++;
    checks++; if ({ex_srca, ex_srcb, ex_wdata, ex_write_reg} !== 101'd0) $display("FAIL reset_data: got %h %h %h %0d exp 0", ex_srca, ex_srcb, ex_wdata, ex_write_reg); else passed++;
    rst_n = 1'b1;
    tick();
    // first edge with rst_n = 1 loads the add
    checks++; if (ctrl !== 6'b110000) $display("FAIL first_load_ctrl: got %b exp %b", ctrl, 6'b110000); else passed++;
  endtask

  task automatic test_add();
    load(32'h00851020, 32'd7, 32'd9);
    checks++; if (ex_alu_control !== 3'b000) $display("FAIL add_alu: got %b exp %b", ex_alu_control, 3'b000); else passed++;
    checks++; if (ex_srca !== 32'd7 || ex_srcb !== 32'd9) $display("FAIL add_src: got %0d %0d exp 7 9", ex_srca, ex_srcb); else passed++;
    checks++; if (ex_write_reg !== 5'd2) $display("FAIL add_wreg: got %0d exp 2", ex_write_reg); else passed++;
    checks++; if (ctrl !== 6'b110000) $display("FAIL add_ctrl: got %b exp %b", ctrl, 6'b110000); else passed++;
  endtask

  task automatic test_rtype_funcs();
    logic [31:0] ins [4];
    logic [2:0]  alu [4];
    ins[0] = 32'h00851022; alu[0] = 3'b001;
    ins[1] = 32'h00851024; alu[1] = 3'b010;
    ins[2] = 32'h00851025; alu[2] = 3'b011;
    ins[3] = 32'h0085102A; alu[3] = 3'b100;
    for (int k = 0; k < 4; k++) begin
      load(ins[k], 32'h1111_0000 + k, 32'h2222_0000 + k);
      checks++; if (ex_alu_control !== alu[k] || ex_srcb !== (32'h2222_0000 + k) || ex_write_reg !== 5'd2 || ctrl !== 6'b110000)
        $display("FAIL rtype_%0d: got alu=%b srcb=%h wreg=%0d ctrl=%b exp alu=%b srcb=%h wreg=2 ctrl=110000",
                 k, ex_alu_control, ex_srcb, ex_write_reg, ctrl, alu[k], 32'h2222_0000 + k);
      else passed++;
    end
  endtask

  task automatic test_lw_sw();
    load(32'h8C22FFFC, 32'h0000_1000, 32'hDEAD_BEEF);
    checks++; if (ex_srcb !== 32'hFFFFFFFC) $display("FAIL lw_srcb: got %h exp %h", ex_srcb, 32'hFFFFFFFC); else passed++;
    checks++; if (ex_alu_control !== 3'b000 || ex_write_reg !== 5'd2) $display("FAIL lw_alu_wreg: got %b %0d exp 000 2", ex_alu_control, ex_write_reg); else passed++;
    checks++; if (ctrl !== 6'b110100) $display("FAIL lw_ctrl: got %b exp %b", ctrl, 6'b110100); else passed++;
    load(32'hAC230008, 32'h0000_2000, 32'h5555_AAAA);
    checks++; if (ex_srcb !== 32'h8 || ex_wdata !== 32'h5555_AAAA || ex_write_reg !== 5'd3) $display("FAIL sw_data: got %h %h %0d exp 8 5555aaaa 3", ex_srcb, ex_wdata, ex_write_reg); else passed++;
    checks++; if (ctrl !== 6'b101000) $display("FAIL sw_ctrl: got %b exp %b", ctrl, 6'b101000); else passed++;
  endtask

  task automatic test_immediates();
    load(32'h3C011234, 32'd0, 32'd0);
    checks++; if (ex_srcb !== 32'h12340000 || ex_alu_control !== 3'b101) $display("FAIL lui: got %h %b exp 12340000 101", ex_srcb, ex_alu_control); else passed++;
    load(32'h3421FFFF, 32'd5, 32'd0);
    checks++; if (ex_srcb !== 32'h0000FFFF || ex_alu_control !== 3'b011 || ex_write_reg !== 5'd1) $display("FAIL ori: got %h %b %0d exp 0000ffff 011 1", ex_srcb, ex_alu_control, ex_write_reg); else passed++;
    load(32'h2005FFFF, 32'd3, 32'd0);
    checks++; if (ex_srcb !== 32'hFFFFFFFF || ex_alu_control !== 3'b000 || ex_write_reg !== 5'd5 || ctrl !== 6'b110000) $display("FAIL addi: got %h %b %0d %b", ex_srcb, ex_alu_control, ex_write_reg, ctrl); else passed++;
    load(32'h28268000, 32'd3, 32'd0);
    checks++; if (ex_srcb !== 32'hFFFF8000 || ex_alu_control !== 3'b100 || ex_write_reg !== 5'd6) $display("FAIL slti: got %h %b %0d exp ffff8000 100 6", ex_srcb, ex_alu_control, ex_write_reg); else passed++;
    load(32'h30278000, 32'd3, 32'd0);
    checks++; if (ex_srcb !== 32'h00008000 || ex_alu_control !== 3'b010 || ex_write_reg !== 5'd7) $display("FAIL andi: got %h %b %0d exp 00008000 010 7", ex_srcb, ex_alu_control, ex_write_reg); else passed++;
    checks++; if (ex_srca !== 32'd3) $display("FAIL andi_srca: got %0d exp 3", ex_srca); else passed++;
  endtask

  task automatic test_stall();
    load(32'h10220004, 32'd11, 32'd22);
    checks++; if (ex_alu_control !== 3'b001 || ctrl !== 6'b100010 || ex_srcb !== 32'd22) $display("FAIL beq: got %b %b %0d exp 001 100010 22", ex_alu_control, ctrl, ex_srcb); else passed++;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      instr = (k == 1) ? 32'hFC000000 : 32'h00851020; rd1 = 32'd99 + k; rd2 = 32'd77;
      tick();
      checks++; if (ex_alu_control !== 3'b001 || ctrl !== 6'b100010 || ex_srca !== 32'd11 || ex_srcb !== 32'd22)
        $display("FAIL stall_hold_%0d: got alu=%b ctrl=%b srca=%0d srcb=%0d exp 001 100010 11 22", k, ex_alu_control, ctrl, ex_srca, ex_srcb);
      else passed++;
    end
    stall = 1'b0;
    tick();
    checks++; if (ex_alu_control !== 3'b000 || ctrl !== 6'b110000 || ex_srca !== 32'd101) $display("FAIL stall_release: got %b %b %0d exp 000 110000 101", ex_alu_control, ctrl, ex_srca); else passed++;
  endtask

  task automatic test_flush();
    load(32'hAC230008, 32'd1, 32'd2);
    flush = 1'b1; stall = 1'b1;
    tick();
    checks++; if (ctrl !== 6'b000000) $display("FAIL flush_over_stall: got %b exp %b", ctrl, 6'b000000); else passed++;
    flush = 1'b0; stall = 1'b0;
    load(32'h8C22FFFC, 32'd1, 32'd2);
    flush = 1'b1;
    tick();
    checks++; if (ctrl !== 6'b000000) $display("FAIL flush_only: got %b exp %b", ctrl, 6'b000000); else passed++;
    flush = 1'b0;
    in_valid = 1'b0; instr = 32'h00851020;
    tick();
    checks++; if (ctrl !== 6'b000000) $display("FAIL not_valid_bubble: got %b exp %b", ctrl, 6'b000000); else passed++;
  endtask

  task automatic test_illegal();
    load(32'hFC000000, 32'd1, 32'd2);
    checks++; if (ctrl !== 6'b000001 || ex_alu_control !== 3'b000) $display("FAIL illegal_op: got %b %b exp 000001 000", ctrl, ex_alu_control); else passed++;
    load(32'h00000000, 32'd1, 32'd2);
    checks++; if (ctrl !== 6'b000001) $display("FAIL illegal_sll0: got %b exp %b", ctrl, 6'b000001); else passed++;
    load(32'h00851021, 32'd1, 32'd2);
    checks++; if (ctrl !== 6'b000001 || ex_alu_control !== 3'b000) $display("FAIL illegal_funct: got %b %b exp 000001 000", ctrl, ex_alu_control); else passed++;
    load(32'h00851020, 32'd1, 32'd2);
    checks++; if (ctrl !== 6'b110000) $display("FAIL illegal_clears: got %b exp %b", ctrl, 6'b110000); else passed++;
  endtask

  task automatic test_reset_mid_stall();
    load(32'h00851025, 32'd4, 32'd5);
    stall = 1'b1; flush = 1'b1; rst_n = 1'b0;
    tick();
    checks++; if (ctrl !== 6'b000000 || ex_alu_control !== 3'b000 || ex_srca !== 32'd0 || ex_srcb !== 32'd0 || ex_write_reg !== 5'd0)
      $display("FAIL reset_mid_stall: got ctrl=%b alu=%b srca=%h srcb=%h wreg=%0d exp all 0", ctrl, ex_alu_control, ex_srca, ex_srcb, ex_write_reg);
    else passed++;
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
    load(32'h0085102A, 32'd4, 32'd5);
    checks++; if (ex_alu_control !== 3'b100 || ctrl !== 6'b110000) $display("FAIL after_reset_load: got %b %b exp 100 110000", ex_alu_control, ctrl); else passed++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_rtype_funcs();
    test_lw_sw();
    test_immediates();
    test_stall();
    test_flush();
    test_illegal();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
